// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch predictor blocks.
//   ctr_t        : 2-bit saturating counter state (SNT/LNT/LT/ST)
//   ctr_next()   : saturating counter update for a resolved outcome
//   ctr_predict(): taken prediction for a counter state
// -----------------------------------------------------------------------------
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_LNT = 2'b01;
  localparam ctr_t CTR_LT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  // Taken moves one step toward ST, not-taken one step toward SNT; both
  // ends saturate.
  function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
    ctr_t nxt;
    nxt = cur;
    if (taken) begin
      if (cur != CTR_ST) nxt = cur + 2'd1;
    end else begin
      if (cur != CTR_SNT) nxt = cur - 2'd1;
    end
    return nxt;
  endfunction

  // LT and ST are exactly the states with the upper bit set.
  function automatic logic ctr_predict(input ctr_t cur);
    return cur[1];
  endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// -----------------------------------------------------------------------------
// bp_update_fifo
// Strict FIFO holding pending BHT updates as {index, taken} words.
// Ports:
//   clk       : clock
//   clear     : synchronous clear of pointers and count (wins over push/pop)
//   push      : write push_data (caller guarantees space or a same-cycle pop)
//   push_data : entry to enqueue
//   pop       : drop the head entry (caller guarantees not empty)
//   pop_data  : current head entry
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : number of stored entries
// -----------------------------------------------------------------------------
module bp_update_fifo #(
  parameter int W     = 7,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // Pointers are AW bits wide, so wrap modulo DEPTH falls out naturally.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; entries are only ever read
  // behind a valid count, and leaving it out keeps the array a plain
  // register file without a reset fan-out.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wptr] <= push_data;
  end

  assign pop_data = mem[rptr];
  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);

endmodule

// File: rtl/bht_controller.sv
// -----------------------------------------------------------------------------
// bht_controller
// Sequencer/arbiter for a direct-mapped table of 2-bit saturating counters.
// After reset an INIT sweep writes SNT to every entry, one per cycle; then
// RUN arbitrates a single table access per cycle between fetch lookups and
// queued execute-stage updates.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   lk_valid/lk_pc  : lookup request, index = lk_pc[IDX_W+1:2]
//   lk_ready        : lookup granted this cycle
//   lk_resp_valid   : registered, one cycle after a grant
//   lk_taken        : registered prediction for the granted lookup
//   up_valid/up_pc/up_taken : resolved-branch update request
//   up_ready        : update queue accepts this cycle
//   q_count         : queued update count
//   busy            : INIT sweep in progress
// -----------------------------------------------------------------------------
module bht_controller
  import bp_pkg::*;
#(
  parameter int IDX_W   = 6,
  parameter int Q_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        lk_valid,
  input  logic [31:0]                 lk_pc,
  output logic                        lk_ready,
  output logic                        lk_resp_valid,
  output logic                        lk_taken,
  input  logic                        up_valid,
  input  logic [31:0]                 up_pc,
  input  logic                        up_taken,
  output logic                        up_ready,
  output logic [$clog2(Q_DEPTH):0]    q_count,
  output logic                        busy
);

  localparam int N = 1 << IDX_W;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] sweep;
  ctr_t             tbl [N];

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W:0]   q_in;
  logic [IDX_W:0]   q_head;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;
  logic             q_push;
  logic             q_pop;
  logic             q_full;
  logic             q_empty;
  logic             grant;
  logic             run;

  // Only the index slice of each PC addresses the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc[31:IDX_W+2], lk_pc[1:0],
                            up_pc[31:IDX_W+2], up_pc[1:0]};

  assign lk_idx     = lk_pc[IDX_W+1:2];
  assign q_in       = {up_pc[IDX_W+1:2], up_taken};
  assign head_idx   = q_head[IDX_W:1];
  assign head_taken = q_head[0];

  // Arbitration: a full queue forces a drain, otherwise lookups win and
  // the queue drains on otherwise idle cycles.
  // NOTE: every signal driven here gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    run   = (state == ST_RUN);
    grant = 1'b0;
    q_pop = 1'b0;
    if (run) begin
      if (q_full)          q_pop = 1'b1;
      else if (lk_valid)   grant = 1'b1;
      else if (!q_empty)   q_pop = 1'b1;
    end
  end

  // A same-cycle pop frees the slot a push needs, so a full queue still
  // accepts while it drains.
  assign up_ready = run && (!q_full || q_pop);
  assign q_push   = up_valid && up_ready;
  assign lk_ready = grant;
  assign busy     = (state == ST_INIT);

  bp_update_fifo #(
    .W     (IDX_W + 1),
    .DEPTH (Q_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clear     (reset),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
      sweep <= '0;
    end else if (state == ST_INIT) begin
      sweep <= sweep + IDX_W'(1);
      if (sweep == '1) state <= ST_RUN;
    end
  end

  // The sweep is the table's only initialisation; lookups and updates are
  // exclusive in RUN, so a single write port covers both.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      tbl[sweep] <= CTR_SNT;
    end else if (q_pop && !reset) begin
      tbl[head_idx] <= ctr_next(tbl[head_idx], head_taken);
    end
  end

  // No forwarding: the response reflects the table before any update
  // still sitting in the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      lk_resp_valid <= 1'b0;
      lk_taken      <= 1'b0;
    end else begin
      lk_resp_valid <= grant;
      lk_taken      <= grant && ctr_predict(tbl[lk_idx]);
    end
  end

endmodule
